// File: rtl/prewish_loader.sv
// Load-button debouncer and DIP-switch sampler feeding the mask path.
// Each accepted press/release pair emits one strobe carrying the DIP value seen at release.
module prewish_loader #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int ALIVE_BITS    = 23
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_button_n,
  input  logic [7:0] i_dip,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_pressed,
  output logic       o_alive
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;
  localparam logic [DEBOUNCE_BITS-1:0] MAX = '1;

  logic [1:0]               btn_sync_q;
  logic [7:0]               dip_s1_q, dip_s2_q;
  logic [1:0]               state_q, state_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     stb_q, stb_d;
  logic [7:0]               dat_q, dat_d;
  logic                     pressed_q, pressed_d;
  logic [ALIVE_BITS-1:0]    alive_q;
  logic                     btn_s;

  assign btn_s = btn_sync_q[1];

  // Synchronizers reset to "released" so reset never fakes a press.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      btn_sync_q <= 2'b11;
      dip_s1_q   <= 8'h00;
      dip_s2_q   <= 8'h00;
    end else begin
      btn_sync_q <= {btn_sync_q[0], i_button_n};
      dip_s1_q   <= i_dip;
      dip_s2_q   <= dip_s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stb_d     = 1'b0;
    dat_d     = dat_q;
    pressed_d = pressed_q;
    case (state_q)
      IDLE: if (!btn_s) begin
        state_d = PRESS_DB;
        cnt_d   = '0;
      end
      PRESS_DB: begin
        if (btn_s) state_d = IDLE;
        else if (cnt_q == MAX) begin
          state_d   = HELD;
          pressed_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      HELD: if (btn_s) begin
        state_d = REL_DB;
        cnt_d   = '0;
      end
      REL_DB: begin
        // A low during release debounce is bounce; the press is still in progress.
        if (!btn_s) state_d = HELD;
        else if (cnt_q == MAX) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          dat_d     = dip_s2_q;
          stb_d     = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stb_q     <= 1'b0;
      dat_q     <= 8'h00;
      pressed_q <= 1'b0;
      alive_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      dat_q     <= dat_d;
      pressed_q <= pressed_d;
      alive_q   <= alive_q + 1'b1;
    end
  end

  assign STB_O     = stb_q;
  assign DAT_O     = dat_q;
  assign o_pressed = pressed_q;
  assign o_alive   = alive_q[ALIVE_BITS-1];

endmodule

// File: doc/prewish_loader.md
Name: prewish_loader

Overview:
- Upstream input stage for the mask path: debounces the board's load button and samples the 8-position DIP switch.
- On each debounced button release it emits a one-cycle strobe and the captured 8-bit mask toward prewish_mentor (its STB_I/DAT_I).
- Replaces the controller's timed fake-mask generator as the source of user masks.

Parameters:
- DEBOUNCE_BITS, 16, width of debounce counter. A level must hold 2^DEBOUNCE_BITS consecutive synchronized cycles to be accepted. Benches use 2.
- ALIVE_BITS, 23, width of free-running alive counter. o_alive is its MSB.

Ports:
- CLK_I  in  1  system clock (single clock domain).
- RST_I  in  1  asynchronous, active-low reset.
- i_button_n  in  1  raw load button, active-low (pulled up; 0 = pressed), asynchronous to CLK_I.
- i_dip  in  8  raw DIP switch levels, asynchronous to CLK_I.
- STB_O  out  1  one-cycle load strobe to mentor.
- DAT_O  out  8  captured mask, valid when STB_O=1; held between loads.
- o_pressed  out  1  debounced button level (1 = accepted press in progress).
- o_alive  out  1  heartbeat for a status LED.

Behaviour:
- Reset (RST_I=0, async): btn sync flops <= 1 (released); dip sync flops <= 0; state <= IDLE; cnt <= 0; STB_O=0, DAT_O=8'h00, o_pressed=0, alive counter=0. Release of reset is sampled on CLK_I.
- Synchronizers: 2-flop on i_button_n gives btn_s; 2-flop per bit on i_dip gives dip_s. No other logic reads raw pins.
- MAX = 2^DEBOUNCE_BITS - 1. All outputs registered.
- IDLE:
  - btn_s=0 -> PRESS_DB, cnt<=0.
- PRESS_DB:
  - btn_s=1 -> IDLE (glitch rejected).
  - else if cnt==MAX -> HELD, o_pressed<=1.
  - else cnt++.
- HELD:
  - btn_s=1 -> REL_DB, cnt<=0.
  - Held indefinitely is legal; there is no timeout.
- REL_DB:
  - btn_s=0 -> HELD (bounce; o_pressed stays 1).
  - else if cnt==MAX -> IDLE, o_pressed<=0, DAT_O<=dip_s, STB_O<=1.
  - else cnt++.
- STB_O is cleared on the next edge after it is set, so it is high exactly one cycle per accepted press/release pair. There is no ack; the downstream stage samples on STB_O.
- Latency: o_pressed rises at edge 2^DEBOUNCE_BITS+3 after the raw pin falls, counting the first sampling edge as 1. STB_O rises and o_pressed falls at edge 2^DEBOUNCE_BITS+3 after the raw pin rises.
- Mask sampling: DAT_O takes the dip_s value at the strobe edge, i.e. the DIP setting at release time. i_dip must be stable for at least 2 cycles before that edge. DIP changes with no button activity have no effect.
- Glitches: low or high pulses shorter than 2^DEBOUNCE_BITS synchronized cycles produce no state change visible on outputs.
- cnt never wraps; it is only compared and incremented below MAX.
- Reset mid-operation (any state) aborts with no strobe; DAT_O returns to 0.
- Button held low through reset release is treated as a new press: accepted after the normal latency, strobe on its release.
- o_alive: counter increments every cycle and wraps; output = MSB.

Test Plan (DEBOUNCE_BITS=2, ALIVE_BITS=4):
- Reset: assert RST_I=0 mid-clock -> immediately STB_O=0, DAT_O=00, o_pressed=0. Deassert, 20 idle cycles -> no strobe; o_alive toggles every 8 cycles.
- Clean load: i_dip=8'hA8, button low 12 cycles then high -> o_pressed=1 from edge 7 after fall. STB_O=1 for exactly one cycle at edge 7 after rise, with DAT_O=A8 and o_pressed=0 at that edge; DAT_O stays A8 afterwards.
- Press bounce: button low 3 cycles, then high -> o_pressed never 1, STB_O never 1, DAT_O unchanged.
- Release bounce: in HELD, button high 2 cycles, low 5, then high -> o_pressed stays 1 through the bounce; exactly one STB_O pulse, at edge 7 after the final rise.
- DIP at release: i_dip=8'h11 at press, changed to 8'hCA while held, then release -> DAT_O=CA at strobe. A second clean load with i_dip=8'h80 -> DAT_O=80.
- Reset during REL_DB: after 2 high cycles in REL_DB assert reset, then deassert with button high -> no STB_O pulse at any time; DAT_O=00.
